// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  // Wide enough for any DWIDTH up to 64; users slice the low DWIDTH bits.
  localparam int ERR_MAX_W = 64;
  localparam logic [ERR_MAX_W-1:0] ERR_RDATA = '1;

  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both cache-side requester ports and the main-memory port.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
);
  logic              p0_rd;
  logic              p0_wr;
  logic [AWIDTH-1:0] p0_addr;
  logic [DWIDTH-1:0] p0_wdata;
  logic [DWIDTH-1:0] p0_rdata;
  logic              p0_ready;
  logic              p0_err;

  logic              p1_rd;
  logic              p1_wr;
  logic [AWIDTH-1:0] p1_addr;
  logic [DWIDTH-1:0] p1_wdata;
  logic [DWIDTH-1:0] p1_rdata;
  logic              p1_ready;
  logic              p1_err;

  logic              rd_mem;
  logic              wr_mem;
  logic [AWIDTH-1:0] addr_mem;
  logic [DWIDTH-1:0] data_mem_out;
  logic [DWIDTH-1:0] data_mem_in;
  logic              ready_mem;

  logic [1:0]        grant;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p1_rd, p1_wr, p1_addr, p1_wdata,
    input  data_mem_in, ready_mem,
    output p0_rdata, p0_ready, p0_err,
    output p1_rdata, p1_ready, p1_err,
    output rd_mem, wr_mem, addr_mem, data_mem_out,
    output grant, busy
  );

  // Requester / memory-model side.
  modport master (
    output p0_rd, p0_wr, p0_addr, p0_wdata,
    output p1_rd, p1_wr, p1_addr, p1_wdata,
    output data_mem_in, ready_mem,
    input  p0_rdata, p0_ready, p0_err,
    input  p1_rdata, p1_ready, p1_err,
    input  rd_mem, wr_mem, addr_mem, data_mem_out,
    input  grant, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that was not
// granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last_grant == PORT_IMEM) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the instruction-cache (port 0)
// and data-cache (port 1) refill paths with round-robin fairness and timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  localparam int TW    = timer_width(TIMEOUT);
  localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit TO_EN = (TIMEOUT > 0);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_pick;
  logic              w_pick_rd;
  logic              w_pick_wr;
  logic [AWIDTH-1:0] w_pick_addr;
  logic [DWIDTH-1:0] w_pick_wdata;
  logic              w_illegal;
  logic              w_start;
  logic              w_timeout;

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_win;
  logic              r_op;
  logic [TW-1:0]     r_timer;
  logic              r_rd_mem;
  logic              r_wr_mem;
  logic [AWIDTH-1:0] r_addr_mem;
  logic [DWIDTH-1:0] r_data_mem_out;
  logic [1:0]        r_grant;
  logic              r_busy;

  assign w_req = {bus.p1_rd | bus.p1_wr, bus.p0_rd | bus.p0_wr};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last),
    .o_gnt        (w_gnt)
  );

  assign w_pick       = w_gnt[1] ? PORT_DMEM : PORT_IMEM;
  assign w_pick_rd    = w_pick ? bus.p1_rd    : bus.p0_rd;
  assign w_pick_wr    = w_pick ? bus.p1_wr    : bus.p0_wr;
  assign w_pick_addr  = w_pick ? bus.p1_addr  : bus.p0_addr;
  assign w_pick_wdata = w_pick ? bus.p1_wdata : bus.p0_wdata;
  assign w_illegal    = w_pick_rd & w_pick_wr;
  assign w_start      = (r_state == S_IDLE) && (w_req != 2'b00);
  assign w_timeout    = TO_EN && (r_timer == TW'(TLIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last         <= PORT_DMEM;
      r_win          <= PORT_IMEM;
      r_op           <= OP_RD;
      r_timer        <= '0;
      r_rd_mem       <= 1'b0;
      r_wr_mem       <= 1'b0;
      r_addr_mem     <= '0;
      r_data_mem_out <= '0;
      r_grant        <= 2'b00;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_grant        <= w_gnt;
            r_last         <= w_pick;
            r_win          <= w_pick;
            r_op           <= w_pick_wr ? OP_WR : OP_RD;
            r_addr_mem     <= w_pick_addr;
            r_data_mem_out <= w_pick_wdata;
            r_timer        <= '0;
            r_busy         <= 1'b1;
            // A simultaneous read+write never reaches memory.
            if (w_illegal) begin
              r_state <= S_RESP;
            end else begin
              r_state  <= S_BUSY;
              r_rd_mem <= ~w_pick_wr;
              r_wr_mem <= w_pick_wr;
            end
          end
        end
        S_BUSY: begin
          r_timer <= r_timer + TW'(1);
          if (bus.ready_mem || w_timeout) begin
            r_rd_mem <= 1'b0;
            r_wr_mem <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_grant  <= 2'b00;
          r_busy   <= 1'b0;
          r_rd_mem <= 1'b0;
          r_wr_mem <= 1'b0;
        end
      endcase
    end
  end

  // Per-port completion pulse, error qualifier and sticky read data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic              r_ready;
      logic              r_err;
      logic [DWIDTH-1:0] r_rdata;
      logic              w_mine;

      assign w_mine = (r_win == 1'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (w_start && w_illegal && (w_pick == 1'(gi))) begin
            r_ready <= 1'b1;
            r_err   <= 1'b1;
          end else if ((r_state == S_BUSY) && w_mine) begin
            // Completion beats timeout when both land in the same cycle.
            if (bus.ready_mem) begin
              r_ready <= 1'b1;
              if (r_op == OP_RD) begin
                r_rdata <= bus.data_mem_in;
              end
            end else if (w_timeout) begin
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= ERR_RDATA[DWIDTH-1:0];
            end
          end
        end
      end
    end
  endgenerate

  assign bus.p0_ready     = g_port[0].r_ready;
  assign bus.p0_err       = g_port[0].r_err;
  assign bus.p0_rdata     = g_port[0].r_rdata;
  assign bus.p1_ready     = g_port[1].r_ready;
  assign bus.p1_err       = g_port[1].r_err;
  assign bus.p1_rdata     = g_port[1].r_rdata;
  assign bus.rd_mem       = r_rd_mem;
  assign bus.wr_mem       = r_wr_mem;
  assign bus.addr_mem     = r_addr_mem;
  assign bus.data_mem_out = r_data_mem_out;
  assign bus.grant        = r_grant;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] exp_g;

  mem_port_arbiter_if #(.AWIDTH(9), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(9), .DWIDTH(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.p0_rd = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_rd = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.ready_mem = 1'b0; bus.data_mem_in = '0;
    step(); step();

    // Reset state
    chk("rst_rd_mem",   bus.rd_mem,   0);
    chk("rst_wr_mem",   bus.wr_mem,   0);
    chk("rst_grant",    bus.grant,    0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_p0_ready", bus.p0_ready, 0);
    chk("rst_p1_ready", bus.p1_ready, 0);
    chk("rst_p0_rdata", bus.p0_rdata, 0);
    chk("rst_p1_rdata", bus.p1_rdata, 0);
    chk("rst_addr_mem", bus.addr_mem, 0);
    reset = 1'b0;
    step();

    // Single read, memory answers in the 2nd rd_mem cycle
    bus.p0_rd = 1'b1; bus.p0_addr = 9'h040;
    step();
    chk("t1_rd_mem_c1", bus.rd_mem,   1);
    chk("t1_addr_mem",  bus.addr_mem, 9'h040);
    chk("t1_grant",     bus.grant,    2'b01);
    chk("t1_busy",      bus.busy,     1);
    step();
    chk("t1_rd_mem_c2", bus.rd_mem,   1);
    chk("t1_p0_early",  bus.p0_ready, 0);
    bus.ready_mem = 1'b1; bus.data_mem_in = 32'hCAFE_0001;
    step();
    chk("t1_rd_mem_off", bus.rd_mem,   0);
    chk("t1_p0_ready",   bus.p0_ready, 1);
    chk("t1_p0_rdata",   bus.p0_rdata, 32'hCAFE_0001);
    chk("t1_p0_err",     bus.p0_err,   0);
    chk("t1_p1_ready",   bus.p1_ready, 0);
    chk("t1_grant_resp", bus.grant,    2'b01);
    $display("txn single_read port=0 rdata=%h", bus.p0_rdata);
    bus.p0_rd = 1'b0; bus.ready_mem = 1'b0;
    step();
    chk("t1_p0_pulse",  bus.p0_ready, 0);
    chk("t1_grant_idle", bus.grant,   0);
    chk("t1_busy_idle", bus.busy,     0);
    chk("t1_p0_hold",   bus.p0_rdata, 32'hCAFE_0001);

    // Simultaneous requests right after reset: port 0 first
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.p0_rd = 1'b1; bus.p0_addr = 9'h011;
    bus.p1_wr = 1'b1; bus.p1_addr = 9'h1F0; bus.p1_wdata = 32'h1234_5678;
    step();
    chk("t2_grant0",  bus.grant,    2'b01);
    chk("t2_rd_mem",  bus.rd_mem,   1);
    chk("t2_wr_mem0", bus.wr_mem,   0);
    chk("t2_addr0",   bus.addr_mem, 9'h011);
    bus.ready_mem = 1'b1; bus.data_mem_in = 32'hAAAA_5555;
    step();
    chk("t2_p0_ready", bus.p0_ready, 1);
    chk("t2_p0_rdata", bus.p0_rdata, 32'hAAAA_5555);
    chk("t2_p1_idle",  bus.p1_ready, 0);
    $display("txn tie_read port=0 rdata=%h", bus.p0_rdata);
    bus.p0_rd = 1'b0; bus.ready_mem = 1'b0;
    step();
    chk("t2_grant_gap", bus.grant, 0);
    step();
    chk("t2_grant1",   bus.grant,        2'b10);
    chk("t2_wr_mem",   bus.wr_mem,       1);
    chk("t2_rd_mem1",  bus.rd_mem,       0);
    chk("t2_addr1",    bus.addr_mem,     9'h1F0);
    chk("t2_wdata",    bus.data_mem_out, 32'h1234_5678);
    bus.ready_mem = 1'b1; bus.data_mem_in = 32'h0BAD_0BAD;
    step();
    chk("t2_p1_ready", bus.p1_ready, 1);
    chk("t2_p1_err",   bus.p1_err,   0);
    chk("t2_wr_off",   bus.wr_mem,   0);
    chk("t2_p1_rdata", bus.p1_rdata, 0);
    $display("txn tie_write port=1 addr=%h", bus.addr_mem);
    bus.p1_wr = 1'b0; bus.ready_mem = 1'b0;
    step();

    // Fairness: both ports hold read requests for 6 transactions
    bus.p0_rd = 1'b1; bus.p0_addr = 9'h020;
    bus.p1_rd = 1'b1; bus.p1_addr = 9'h120;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      chk("t3_grant",  bus.grant,    exp_g);
      chk("t3_rd_mem", bus.rd_mem,   1);
      chk("t3_addr",   bus.addr_mem, (i % 2 == 0) ? 9'h020 : 9'h120);
      bus.ready_mem = 1'b1; bus.data_mem_in = 32'h100 + i;
      step();
      chk("t3_p0_ready", bus.p0_ready, exp_g[0]);
      chk("t3_p1_ready", bus.p1_ready, exp_g[1]);
      chk("t3_rdata", exp_g[0] ? bus.p0_rdata : bus.p1_rdata, 32'h100 + i);
      $display("txn fair idx=%0d grant=%b", i, bus.grant);
      bus.ready_mem = 1'b0;
      step();
    end
    bus.p0_rd = 1'b0; bus.p1_rd = 1'b0;
    step();
    chk("t3_idle", bus.grant, 0);

    // Timeout: port 1 read, memory never answers
    bus.p1_rd = 1'b1; bus.p1_addr = 9'h0AA;
    step();
    chk("t4_grant",  bus.grant,  2'b10);
    chk("t4_rd_mem", bus.rd_mem, 1);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t4_rd_hold", bus.rd_mem,   1);
      chk("t4_no_rdy",  bus.p1_ready, 0);
    end
    step();
    chk("t4_rd_off",   bus.rd_mem,   0);
    chk("t4_p1_ready", bus.p1_ready, 1);
    chk("t4_p1_err",   bus.p1_err,   1);
    chk("t4_p1_rdata", bus.p1_rdata, 32'hFFFF_FFFF);
    chk("t4_p0_ready", bus.p0_ready, 0);
    $display("txn timeout port=1 rdata=%h", bus.p1_rdata);
    bus.p1_rd = 1'b0;
    step();
    chk("t4_pulse", bus.p1_ready, 0);
    chk("t4_err0",  bus.p1_err,   0);
    chk("t4_grant0", bus.grant,   0);
    chk("t4_busy0", bus.busy,     0);

    // Illegal request: read and write together
    bus.p0_rd = 1'b1; bus.p0_wr = 1'b1; bus.p0_addr = 9'h033;
    step();
    chk("t5_rd_mem",   bus.rd_mem,   0);
    chk("t5_wr_mem",   bus.wr_mem,   0);
    chk("t5_p0_ready", bus.p0_ready, 1);
    chk("t5_p0_err",   bus.p0_err,   1);
    chk("t5_grant",    bus.grant,    2'b01);
    $display("txn illegal port=0 err=%b", bus.p0_err);
    bus.p0_rd = 1'b0; bus.p0_wr = 1'b0;
    step();
    chk("t5_pulse",    bus.p0_ready, 0);
    chk("t5_busy",     bus.busy,     0);
    chk("t5_rd_quiet", bus.rd_mem,   0);
    chk("t5_p0_rdata", bus.p0_rdata, 32'h104);

    // Reset during a port-1 write
    bus.p1_wr = 1'b1; bus.p1_addr = 9'h055; bus.p1_wdata = 32'hDEAD_BEEF;
    step();
    chk("t6_wr_mem", bus.wr_mem, 1);
    chk("t6_grant",  bus.grant,  2'b10);
    step();
    chk("t6_wr_hold", bus.wr_mem, 1);
    reset = 1'b1;
    step();
    chk("t6_wr_drop",  bus.wr_mem,   0);
    chk("t6_grant0",   bus.grant,    0);
    chk("t6_busy0",    bus.busy,     0);
    chk("t6_no_ready", bus.p1_ready, 0);
    chk("t6_p1_rdata", bus.p1_rdata, 0);
    reset = 1'b0; bus.p1_wr = 1'b0;
    step();
    chk("t6_still_quiet", bus.p1_ready, 0);
    bus.p0_rd = 1'b1; bus.p0_addr = 9'h0F0;
    bus.p1_rd = 1'b1; bus.p1_addr = 9'h0F1;
    step();
    chk("t6_tie_grant", bus.grant,    2'b01);
    chk("t6_tie_addr",  bus.addr_mem, 9'h0F0);
    bus.ready_mem = 1'b1; bus.data_mem_in = 32'h5A5A_5A5A;
    step();
    chk("t6_p0_ready", bus.p0_ready, 1);
    chk("t6_p0_rdata", bus.p0_rdata, 32'h5A5A_5A5A);
    $display("txn post_reset port=0 rdata=%h", bus.p0_rdata);
    bus.p0_rd = 1'b0; bus.ready_mem = 1'b0;
    step();
    step();
    chk("t6_next_grant", bus.grant, 2'b10);
    bus.ready_mem = 1'b1; bus.data_mem_in = 32'h0000_00F1;
    step();
    chk("t6_p1_ready", bus.p1_ready, 1);
    chk("t6_p1_data",  bus.p1_rdata, 32'h0000_00F1);
    $display("txn post_reset port=1 rdata=%h", bus.p1_rdata);
    bus.p1_rd = 1'b0; bus.ready_mem = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
